// File: rtl/branch_target_predictor.sv
// branch_target_predictor: fully associative branch target buffer with 2-bit direction counters
module branch_target_predictor #(
   parameter int PC_BITS  = 12,
   parameter int DEPTH    = 8,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PC_BITS-1:0]  F_pc,
   input  logic                F_stall,
   input  logic                MEM_stall,
   input  logic                EX_brn,
   input  logic [PC_BITS-1:0]  EX_pc,
   input  logic [PC_BITS-1:0]  EX_alu_out,
   input  logic                EX_true_taken,
   input  logic                flush,
   output logic [PC_BITS-1:0]  F_BP_target_pc,
   output logic                F_BP_taken,
   output logic                EX_mispred,
   output logic [CNT_BITS-1:0] hit_cnt,
   output logic [CNT_BITS-1:0] mispred_cnt
);
   localparam int IW = $clog2(DEPTH);
   logic [DEPTH-1:0]   valid;
   logic [PC_BITS-1:0] tag [DEPTH];
   logic [PC_BITS-1:0] tgt [DEPTH];
   logic [1:0]         cnt [DEPTH];
   logic [IW-1:0]      rr_ptr, f_idx, ex_idx, free_idx, alloc_idx;
   logic               f_hit, ex_hit, free_ok, update_en;
   logic [1:0]         ex_cnt, cnt_nxt;
   // Priority search of all entries; scanning downward lets the lowest index win
   always_comb begin
      f_hit = 1'b0;
      f_idx = '0;
      ex_hit = 1'b0;
      ex_idx = '0;
      free_ok = 1'b0;
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid[i] && tag[i] == F_pc) begin
            f_hit = 1'b1;
            f_idx = IW'(i);
         end
         if (valid[i] && tag[i] == EX_pc) begin
            ex_hit = 1'b1;
            ex_idx = IW'(i);
         end
         if (!valid[i]) begin
            free_ok = 1'b1;
            free_idx = IW'(i);
         end
      end
   end
   assign update_en      = EX_brn && !MEM_stall;
   assign ex_cnt         = cnt[ex_idx];
   assign EX_mispred     = update_en && ((ex_hit && ex_cnt[1]) != EX_true_taken);
   assign cnt_nxt        = EX_true_taken ? ((ex_cnt == 2'd3) ? 2'd3 : ex_cnt + 2'd1)
                                         : ((ex_cnt == 2'd0) ? 2'd0 : ex_cnt - 2'd1);
   assign alloc_idx      = free_ok ? free_idx : rr_ptr;
   assign F_BP_taken     = f_hit && cnt[f_idx][1];
   assign F_BP_target_pc = F_BP_taken ? tgt[f_idx] : (F_stall || MEM_stall) ? F_pc : F_pc + PC_BITS'(1);
   // Table update, allocation/replacement, flush and saturating statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag[i] <= '0;
            tgt[i] <= '0;
            cnt[i] <= '0;
         end
         rr_ptr <= '0;
         hit_cnt <= '0;
         mispred_cnt <= '0;
      end else begin
         if (f_hit && !F_stall && !MEM_stall && !(&hit_cnt)) hit_cnt <= hit_cnt + CNT_BITS'(1);
         if (EX_mispred && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_BITS'(1);
         if (flush) begin
            valid <= '0;
         end else if (update_en) begin
            if (ex_hit) begin
               cnt[ex_idx] <= cnt_nxt;
               if (EX_true_taken) tgt[ex_idx] <= EX_alu_out;
            end else begin
               valid[alloc_idx] <= 1'b1;
               tag[alloc_idx] <= EX_pc;
               tgt[alloc_idx] <= EX_alu_out;
               cnt[alloc_idx] <= EX_true_taken ? 2'd2 : 2'd1;
               if (!free_ok) rr_ptr <= rr_ptr + IW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: table-driven scoreboard bench for branch_target_predictor
module tb_branch_target_predictor;
   typedef struct packed {
      logic        rst, flush, fst, mst, brn, tk;
      logic [11:0] expc, alu, fpc;
      logic        e_tk;
      logic [11:0] e_tgt;
      logic        e_mis;
      logic [15:0] e_hit, e_mc;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst, F_stall, MEM_stall, EX_brn, EX_true_taken, flush;
   logic [11:0] F_pc, EX_pc, EX_alu_out, F_BP_target_pc;
   logic        F_BP_taken, EX_mispred;
   logic [15:0] hit_cnt, mispred_cnt;
   vec_t        tbl[$];
   vec_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          eh = 0;
   int          em = 0;
   branch_target_predictor #(.PC_BITS(12), .DEPTH(8), .CNT_BITS(16)) dut (
      .clk(clk), .rst(rst), .F_pc(F_pc), .F_stall(F_stall), .MEM_stall(MEM_stall),
      .EX_brn(EX_brn), .EX_pc(EX_pc), .EX_alu_out(EX_alu_out), .EX_true_taken(EX_true_taken),
      .flush(flush), .F_BP_target_pc(F_BP_target_pc), .F_BP_taken(F_BP_taken),
      .EX_mispred(EX_mispred), .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt)
   );
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end
   task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0h expected %0h", name, n, act, exp);
      end
   endtask
   task automatic add(input logic r, input logic fl, input logic fs, input logic ms, input logic b,
                      input logic [11:0] epc, input logic [11:0] alu, input logic t, input logic [11:0] fpc,
                      input logic hit, input logic etk, input logic [11:0] etgt, input logic emis);
      vec_t v;
      if (r) begin
         eh = 0;
         em = 0;
      end else begin
         em += int'(emis);
         eh += int'(hit && !fs && !ms);
      end
      v = '{r, fl, fs, ms, b, t, epc, alu, fpc, etk, etgt, emis, 16'(eh), 16'(em)};
      tbl.push_back(v);
   endtask
   task automatic idle(input logic [11:0] fpc, input logic hit, input logic etk, input logic [11:0] etgt);
      add(0, 0, 0, 0, 0, 12'h0, 12'h0, 0, fpc, hit, etk, etgt, 0);
   endtask
   initial begin
      vec_t v;
      vec_t e;
      add(1, 0, 0, 0, 0, 12'h0, 12'h0, 0, 12'h100, 0, 0, 12'h101, 0);
      add(0, 0, 0, 0, 1, 12'h010, 12'h080, 1, 12'h010, 0, 0, 12'h011, 1);
      idle(12'h010, 1, 1, 12'h080);
      add(0, 0, 0, 0, 1, 12'h010, 12'h055, 0, 12'h010, 1, 1, 12'h080, 1);
      idle(12'h010, 1, 0, 12'h011);
      add(0, 0, 0, 0, 1, 12'h010, 12'h0A0, 1, 12'h100, 0, 0, 12'h101, 1);
      idle(12'h010, 1, 1, 12'h0A0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 12'h010, 12'h0A0, 1, 12'h100, 0, 0, 12'h101, 0);
      add(0, 0, 0, 0, 1, 12'h010, 12'h0BB, 0, 12'h100, 0, 0, 12'h101, 1);
      idle(12'h010, 1, 1, 12'h0A0);
      add(0, 0, 0, 1, 1, 12'h020, 12'h0CC, 1, 12'h030, 0, 0, 12'h030, 0);
      idle(12'h020, 0, 0, 12'h021);
      add(0, 0, 1, 0, 0, 12'h0, 12'h0, 0, 12'h010, 1, 1, 12'h0A0, 0);
      add(0, 1, 0, 0, 1, 12'h020, 12'h0CC, 1, 12'h100, 0, 0, 12'h101, 1);
      idle(12'h010, 0, 0, 12'h011);
      idle(12'h020, 0, 0, 12'h021);
      for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 1, 12'h200 + 12'(i), 12'h300 + 12'(i), 1, 12'h100, 0, 0, 12'h101, 1);
      for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 1, 12'h400 + 12'(i), 12'h600 + 12'(i), 1, 12'h100, 0, 0, 12'h101, 1);
      idle(12'h400, 0, 0, 12'h401);
      idle(12'h408, 1, 1, 12'h608);
      idle(12'h401, 1, 1, 12'h601);
      idle(12'h207, 0, 0, 12'h208);
      add(0, 0, 0, 0, 1, 12'h500, 12'h700, 1, 12'h100, 0, 0, 12'h101, 1);
      idle(12'h401, 0, 0, 12'h402);
      idle(12'h402, 1, 1, 12'h602);
      idle(12'h500, 1, 1, 12'h700);
      add(1, 0, 0, 0, 1, 12'h402, 12'h111, 0, 12'h402, 1, 1, 12'h602, 1);
      idle(12'h402, 0, 0, 12'h403);
      idle(12'h000, 0, 0, 12'h001);
      rst = 1'b1;
      flush = 1'b0;
      F_stall = 1'b0;
      MEM_stall = 1'b0;
      EX_brn = 1'b0;
      EX_true_taken = 1'b0;
      F_pc = 12'h0;
      EX_pc = 12'h0;
      EX_alu_out = 12'h0;
      repeat (2) @(posedge clk);
      for (int n = 0; n < tbl.size(); n++) begin
         @(negedge clk);
         v = tbl[n];
         rst = v.rst;
         flush = v.flush;
         F_stall = v.fst;
         MEM_stall = v.mst;
         EX_brn = v.brn;
         EX_pc = v.expc;
         EX_alu_out = v.alu;
         EX_true_taken = v.tk;
         F_pc = v.fpc;
         sb.push_back(v);
         #1;
         e = sb.pop_front();
         chk("taken", n, 32'(F_BP_taken), 32'(e.e_tk));
         chk("target", n, 32'(F_BP_target_pc), 32'(e.e_tgt));
         chk("mispred", n, 32'(EX_mispred), 32'(e.e_mis));
         @(posedge clk);
         #1;
         chk("hit_cnt", n, 32'(hit_cnt), 32'(e.e_hit));
         chk("mispred_cnt", n, 32'(mispred_cnt), 32'(e.e_mc));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 The block SHALL have parameter PC_BITS, default 12, PC and target width.
REQ-002 The block SHALL have parameter DEPTH, default 8, entry count; a power of two, at least 2.
REQ-003 The block SHALL have parameter CNT_BITS, default 16, statistics counter width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- F_pc  in  PC_BITS  fetch PC under lookup
- F_stall  in  1  fetch stalled
- MEM_stall  in  1  memory stage stalled; freezes EX
- EX_brn  in  1  EX holds a branch
- EX_pc  in  PC_BITS  PC of the EX branch
- EX_alu_out  in  PC_BITS  resolved target
- EX_true_taken  in  1  resolved direction
- flush  in  1  invalidate all entries
- F_BP_target_pc  out  PC_BITS  predicted next PC
- F_BP_taken  out  1  predicted taken
- EX_mispred  out  1  stored prediction for the EX branch was wrong
- hit_cnt  out  CNT_BITS  count of fetch lookups that hit
- mispred_cnt  out  CNT_BITS  count of mispredicted updates

Function
REQ-006 Each entry SHALL hold valid, tag (PC_BITS), target (PC_BITS) and a 2-bit saturating counter; the block is fully associative.
REQ-007 Fetch lookup SHALL be combinational: hit = any valid entry with tag == F_pc; the lowest index wins on multiple matches.
REQ-008 F_BP_taken SHALL be 1 only on a hit whose counter is 2 or 3.
REQ-009 F_BP_target_pc SHALL be the hit entry's target when F_BP_taken is 1, else F_pc + 1, or F_pc when F_stall or MEM_stall is 1, truncated to PC_BITS.
REQ-010 EX lookup SHALL use the same match rule on EX_pc; update_en = EX_brn and not MEM_stall.
REQ-011 EX_mispred SHALL be update_en and (ex_pred != EX_true_taken), where ex_pred = ex_hit and counter[1]; it is combinational.
REQ-012 On update_en with an EX hit:
- the counter SHALL increment, saturating at 3, if taken; otherwise it decrements, saturating at 0;
- the target SHALL be written with EX_alu_out only if taken.
REQ-013 On update_en with an EX miss, the block SHALL allocate an entry:
- the lowest-index invalid entry, if one exists; else the entry at replacement pointer rr_ptr;
- write valid = 1, tag = EX_pc, target = EX_alu_out, counter = 2 if taken else 1.
REQ-014 rr_ptr SHALL advance by 1, wrapping DEPTH-1 to 0, only when a valid entry is replaced.
REQ-015 Lookup in the same cycle as an update to the same PC SHALL see pre-update state; there is no bypass.
REQ-016 flush SHALL clear all valid bits on the next edge and override any same-cycle update; counters, targets and rr_ptr are unchanged.
REQ-017 hit_cnt SHALL increment on each edge where the fetch lookup hits and F_stall and MEM_stall are 0, saturating at all-ones.
REQ-018 mispred_cnt SHALL increment on each edge where EX_mispred is 1, saturating at all-ones.
REQ-019 With MEM_stall = 1, no entry, pointer or mispred_cnt state SHALL change.

Reset
REQ-020 rst SHALL take priority over flush and update.
REQ-021 rst SHALL clear on the next edge: all valid bits, tags, targets and counters to 0, rr_ptr to 0, hit_cnt and mispred_cnt to 0.
REQ-022 After reset, outputs SHALL be F_BP_taken = 0, F_BP_target_pc = F_pc + 1 (unstalled) and EX_mispred = 0.
REQ-023 rst asserted mid-operation SHALL discard a same-cycle update.

Verification
REQ-024 Cold miss: after reset, EX update pc 0x010 taken target 0x080 -> EX_mispred = 1, entry 0 counter = 2; next cycle F_pc = 0x010 gives taken = 1, target = 0x080, hit_cnt = 1.
REQ-025 Hysteresis: from counter 2, apply not-taken, then taken -> counter goes 1 then 2; prediction at F_pc is 0 then 1; mispred_cnt increments both times.
REQ-026 Saturation: three taken updates from counter 2 -> counter stays 3; one not-taken -> counter 2, still predicts taken.
REQ-027 Replacement wrap: fill DEPTH = 8 entries, then 9 new PCs -> entries 0..7 then 0 replaced in order, rr_ptr ends at 1; the evicted PC misses.
REQ-028 Stall and flush: an update with MEM_stall = 1 causes no change and F_BP_target_pc = F_pc; flush together with an update -> all entries invalid, no allocation.
REQ-029 Simultaneous events: lookup and update of the same new PC in one cycle -> lookup misses and the next cycle hits; rst with update -> state all zero.
